stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//   Registered, flow-controlled 1-to-NUM_CH demultiplexer. Steers a valid/ready input stream to one
//   of NUM_CH output channels, each buffered by a DEPTH-entry FIFO so that a stalled consumer only
//   back-pressures its own channel. Parametrised successor of the fixed 4x8-bit combinational demux.
//   Sits between the shared uplink mux and per-site consumers (Lib/FD/School/Ribs class endpoints).
// PARAMETERS
//   DATA_W  8  payload width, bits (>=1)
//   NUM_CH  4  output channel count (2..16, need not be a power of 2)
//   DEPTH   2  entries per channel FIFO (power of 2, >=2)
// PORTS
//   clk        in   1              single clock, rising edge
//   rst_n      in   1              asynchronous, active-low reset
//   enable     in   1              0: in_ready forced low, nothing accepted; outputs keep draining
//   in_valid   in   1              input beat valid
//   in_ready   out  1              input beat accepted when in_valid & in_ready
//   in_sel     in   SEL_W          destination channel; SEL_W = max(1,$clog2(NUM_CH))
//   in_data    in   DATA_W         payload
//   out_valid  out  NUM_CH         per-channel valid = FIFO non-empty
//   out_ready  in   NUM_CH         per-channel consumer ready
//   out_data   out  NUM_CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W]; head of FIFO c
//   sel_err    out  1              1-cycle pulse: beat with in_sel >= NUM_CH accepted and discarded
//   drop_cnt   out  16             only with STREAM_DEMUX_DROP_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async assert, sync-release assumed upstream): all FIFOs empty, pointers/counts 0,
//     out_valid=0, out_data=0, sel_err=0, drop_cnt=0. Reset mid-stream discards all buffered beats.
//   - in_ready = enable & (in_sel >= NUM_CH | ~full[in_sel]); registered full flags only, so
//     in_ready never depends combinationally on out_ready (push into a full FIFO refused even if it
//     pops the same cycle).
//   - Push: beat written to FIFO[in_sel] at accepting edge; out_valid[in_sel] high from next cycle
//     (latency 1). In-order per channel; no ordering guarantee across channels.
//   - Pop: FIFO c advances on out_valid[c] & out_ready[c]; out_data holds stable while valid & ~ready.
//   - Simultaneous push+pop same channel (not full): count unchanged, both performed; on empty FIFO
//     pop cannot occur (out_valid=0), push lands, valid next cycle.
//   - Full: count==DEPTH; empty: count==0; pointers wrap modulo DEPTH, count is $clog2(DEPTH)+1 bits.
//   - Out-of-range in_sel (only when NUM_CH not power of 2): beat accepted if enable, discarded,
//     sel_err pulses the following cycle; no FIFO touched.
//   - enable deassert mid-stream: takes effect same cycle (in_ready low); buffered data still drains.
//   - in_sel/in_data sampled only on accept; X on them when in_valid=0 must not propagate.
// CONFIGURATION
//   STREAM_DEMUX_DROP_CNT_EN defined: drop_cnt port present; 16-bit counter increments on each
//     discarded (out-of-range) beat, saturates at 16'hFFFF, cleared only by rst_n.
//   Not defined: drop_cnt port and counter absent; sel_err still generated.
// STRUCTURE
//   Package stream_demux_pkg: SEL_W/CNT_W helper functions (clog2 with min 1), DROP_CNT_W=16,
//     DROP_CNT_MAX constant.
//   Sub-module demux_chan_fifo (DATA_W, DEPTH): sync FIFO with push/pop/full/empty/head data;
//     instantiated NUM_CH times in a generate loop. Top holds steering, in_ready, sel_err, counter.
// TESTING
//   1 Reset: assert rst_n=0 mid-run with 2 beats buffered -> out_valid=0, out_data=0 immediately,
//     in_ready=1 after release with enable=1.
//   2 Routing: DATA_W=8,NUM_CH=4; send 8'hA5 sel=2, out_ready=all 1 -> out_valid=4'b0100 next cycle,
//     out_data[23:16]=8'hA5, other lanes untouched.
//   3 Back-pressure: out_ready[1]=0, send 3 beats sel=1 (DEPTH=2) -> first 2 accepted, in_ready=0 on
//     third; other channels still accept; raise out_ready[1] -> beats 11,22,33 emerge in order.
//   4 Push+pop same cycle on ch0 with count=1 -> count stays 1, no beat lost or duplicated.
//   5 Out-of-range: NUM_CH=3, sel=3, data 8'h5A -> in_ready=1, sel_err pulse, no out_valid; with
//     STREAM_DEMUX_DROP_CNT_EN drop_cnt=1; force 65536 drops -> holds 16'hFFFF.
//   6 enable=0 with in_valid=1 -> in_ready=0, buffered beats continue to drain; random stimulus
//     scoreboard vs per-channel queue model for 10k beats.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared sizing helpers and drop-counter constants for stream_demux.
// STREAM_DEMUX_DROP_CNT_EN selects the optional drop counter in the top level.
package stream_demux_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

    // $clog2 with a floor of 1 so that 1- and 2-entry ranges still get a real bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sel_w(input int num_ch);
        return clog2_min1(num_ch);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO: registered full/empty flags, head-of-queue output.
// Storage is cleared by reset so the head reads as zero while empty after reset.
module demux_chan_fifo
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);
    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Flow-controlled 1-to-NUM_CH demultiplexer with a FIFO per output channel.
// Define STREAM_DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [sel_w(NUM_CH)-1:0]  in_sel,
    input  logic [DATA_W-1:0]         in_data,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*DATA_W-1:0]  out_data,
    output logic                      sel_err
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);
    localparam int SEL_W = sel_w(NUM_CH);
    localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_sel_hit;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic              w_in_range;
    logic              w_sel_full;
    logic              w_accept;
    logic              r_sel_err;

    assign w_in_range = ({1'b0, in_sel} < NUM_CH_V);

    // One-hot decode of the destination plus its registered full flag.
    always_comb begin
        w_sel_hit  = '0;
        w_sel_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_sel == SEL_W'(c)) begin
                w_sel_hit[c] = 1'b1;
                w_sel_full   = w_full[c];
            end
        end
    end

    assign in_ready  = enable & (~w_in_range | ~w_sel_full);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_sel_hit & {NUM_CH{w_accept}};
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        demux_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_push      (w_push[c]),
            .i_push_data (in_data),
            .i_pop       (w_pop[c]),
            .o_full      (w_full[c]),
            .o_empty     (w_empty[c]),
            .o_head      (out_data[c*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_accept & ~w_in_range;
        end
    end

    assign sel_err = r_sel_err;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a 4-channel instance with a per-channel queue
// model and monitor, plus a 3-channel instance for out-of-range select handling.
module tb_stream_demux;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_enable, a_in_valid, a_in_ready, a_sel_err;
    logic [1:0]  a_in_sel;
    logic [7:0]  a_in_data;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;

    logic        b_enable, b_in_valid, b_in_ready, b_sel_err;
    logic [1:0]  b_in_sel;
    logic [7:0]  b_in_data;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] a_drop_cnt, b_drop_cnt;
`endif

    logic [7:0]  exp_q[4][$];
    int          checks = 0;
    int          errors = 0;
    logic        acc;
    int          n_acc;
    logic [3:0]  ordy;

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .NUM_CH(4), .DEPTH(DEPTH)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(a_enable), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_sel(a_in_sel), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .sel_err(a_sel_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_cnt(a_drop_cnt)
`endif
    );

    stream_demux #(.DATA_W(8), .NUM_CH(3), .DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_sel(b_in_sel), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .sel_err(b_sel_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_cnt(b_drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle on the 4-channel DUT; entered and left 1 time unit after a rising edge.
    task automatic step_a(input logic v, input logic [1:0] sel, input logic [7:0] d,
                          input logic [3:0] rdy, input logic en, output logic accepted);
        int occ;
        a_in_valid  = v;
        a_in_sel    = sel;
        a_in_data   = d;
        a_out_ready = rdy;
        a_enable    = en;
        occ = exp_q[sel].size();
        @(negedge clk);
        accepted = v & a_in_ready;
        if (v) chk("in_ready_model", {31'd0, a_in_ready}, {31'd0, (en && occ < DEPTH)});
        @(posedge clk);
        if (accepted) exp_q[sel].push_back(d);
        #1;
    endtask

    task automatic idle_a(input int n);
        logic unused_acc;
        for (int i = 0; i < n; i++) step_a(1'b0, 2'd0, 8'd0, 4'hF, 1'b1, unused_acc);
    endtask

    // Monitor: model occupancy must match out_valid; each handshake pops the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_sel_err_idle", {31'd0, a_sel_err}, 32'd0);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("out_valid_ch%0d", c), {31'd0, a_out_valid[c]},
                    {31'd0, exp_q[c].size() != 0});
                if (a_out_valid[c] && a_out_ready[c] && exp_q[c].size() != 0) begin
                    chk($sformatf("out_data_ch%0d", c), {24'd0, a_out_data[c*8 +: 8]},
                        {24'd0, exp_q[c].pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_enable = 1'b1; a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
        b_enable = 1'b1; b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {28'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_sel_err", {31'd0, a_sel_err}, 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("rst_drop_cnt", {16'd0, b_drop_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing to channel 2.
        step_a(1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, acc);
        chk("route_valid", {28'd0, a_out_valid}, 32'h4);
        chk("route_data", {24'd0, a_out_data[23:16]}, 32'hA5);
        idle_a(2);

        // Back-pressure on channel 1 while channel 0 keeps flowing.
        step_a(1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, acc);
        step_a(1'b1, 2'd1, 8'h22, 4'b1101, 1'b1, acc);
        step_a(1'b1, 2'd1, 8'h33, 4'b1101, 1'b1, acc);
        chk("bp_third_refused", {31'd0, acc}, 32'd0);
        chk("bp_head_stable", {24'd0, a_out_data[15:8]}, 32'h11);
        step_a(1'b1, 2'd0, 8'h44, 4'b1101, 1'b1, acc);
        chk("bp_other_ch_accepts", {31'd0, acc}, 32'd1);
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step_a(1'b1, 2'd1, 8'h33, 4'hF, 1'b1, acc);
        chk("bp_third_late_accept", {31'd0, acc}, 32'd1);
        idle_a(4);

        // Push and pop on channel 0 in the same cycle with one beat queued.
        step_a(1'b1, 2'd0, 8'hC1, 4'b1110, 1'b1, acc);
        step_a(1'b1, 2'd0, 8'hC2, 4'b1111, 1'b1, acc);
        chk("pp_accept", {31'd0, acc}, 32'd1);
        chk("pp_valid", {31'd0, a_out_valid[0]}, 32'd1);
        chk("pp_data", {24'd0, a_out_data[7:0]}, 32'hC2);
        idle_a(1);
        chk("pp_drained", {31'd0, a_out_valid[0]}, 32'd0);

        // enable low: nothing accepted, channel 3 still drains.
        step_a(1'b1, 2'd3, 8'hD1, 4'b0111, 1'b1, acc);
        step_a(1'b1, 2'd3, 8'hD2, 4'b0111, 1'b1, acc);
        step_a(1'b1, 2'd3, 8'hD3, 4'b0111, 1'b0, acc);
        chk("en0_refused", {31'd0, acc}, 32'd0);
        step_a(1'b1, 2'd3, 8'hD4, 4'b1111, 1'b0, acc);
        step_a(1'b1, 2'd3, 8'hD5, 4'b1111, 1'b0, acc);
        chk("en0_drained", {31'd0, a_out_valid[3]}, 32'd0);

        // Reset with two beats buffered.
        step_a(1'b1, 2'd1, 8'hE1, 4'b0000, 1'b1, acc);
        step_a(1'b1, 2'd2, 8'hE2, 4'b0000, 1'b1, acc);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {28'd0, a_out_valid}, 32'd0);
        chk("midrst_out_data", a_out_data, 32'd0);
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_enable = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Out-of-range select on the 3-channel instance.
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h5A;
        @(negedge clk);
        chk("oor_in_ready", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("oor_sel_err", {31'd0, b_sel_err}, 32'd1);
        chk("oor_no_valid", {29'd0, b_out_valid}, 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("oor_drop_cnt1", {16'd0, b_drop_cnt}, 32'd1);
`endif
        @(posedge clk);
        #1;
        chk("oor_sel_err_pulse", {31'd0, b_sel_err}, 32'd0);
        b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h3C;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_route_valid", {29'd0, b_out_valid}, 32'h2);
        chk("b_route_data", {24'd0, b_out_data[15:8]}, 32'h3C);
        chk("b_inrange_no_err", {31'd0, b_sel_err}, 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        b_in_valid = 1'b1; b_in_sel = 2'd3;
        repeat (65535) @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("drop_cnt_sat", {16'd0, b_drop_cnt}, 32'hFFFF);
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("drop_cnt_hold", {16'd0, b_drop_cnt}, 32'hFFFF);
`endif

        // Random traffic against the queue model.
        n_acc = 0;
        for (int i = 0; i < 40000 && n_acc < 10000; i++) begin
            for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 3) != 0);
            step_a($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                   ordy, $urandom_range(0, 15) != 0, acc);
            if (acc) n_acc++;
        end
        chk("random_beat_count", n_acc, 32'd10000);

        for (int i = 0; i < 10 && (exp_q[0].size() + exp_q[1].size() +
                                   exp_q[2].size() + exp_q[3].size()) != 0; i++) idle_a(1);
        for (int c = 0; c < 4; c++) chk($sformatf("final_empty_ch%0d", c), exp_q[c].size(), 32'd0);
        chk("final_out_valid", {28'd0, a_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
